// File: rtl/dev_bus_arbiter.sv
// Two-master round-robin arbiter for the devctrl bus, holding each grant for one
// transaction and aborting transactions the device never finishes.
module dev_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF,
  parameter int unsigned CNT_W          = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0Enable_i,
  input  logic        m0Write_i,
  input  logic [31:0] m0Addr_i,
  input  logic [31:0] m0DataSave_i,
  input  logic [3:0]  m0ByteSelect_i,
  output logic        m0Busy_o,
  output logic [31:0] m0DataLoad_o,
  input  logic        m1Enable_i,
  input  logic        m1Write_i,
  input  logic [31:0] m1Addr_i,
  input  logic [31:0] m1DataSave_i,
  input  logic [3:0]  m1ByteSelect_i,
  output logic        m1Busy_o,
  output logic [31:0] m1DataLoad_o,
  output logic        devEnable_o,
  output logic        devWrite_o,
  output logic [31:0] devPhysicalAddr_o,
  output logic [31:0] devDataSave_o,
  output logic [3:0]  devByteSelect_o,
  input  logic        devBusy_i,
  input  logic [31:0] devDataLoad_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  localparam logic             WD_ON   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] WD_LAST = WD_ON ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             last_grant;
  logic [CNT_W-1:0] wd_count;

  logic        granted;
  logic        sel_m1;
  logic        sel_enable;
  logic        done;
  logic        abort;
  logic [31:0] load_value;

  assign granted = (state == GNT0) || (state == GNT1);
  assign sel_m1  = (state == GNT1);
  assign sel_enable = sel_m1 ? m1Enable_i : m0Enable_i;

  always_comb begin
    devEnable_o       = 1'b0;
    devWrite_o        = 1'b0;
    devPhysicalAddr_o = '0;
    devDataSave_o     = '0;
    devByteSelect_o   = '0;
    if (granted) begin
      devEnable_o       = sel_enable;
      devWrite_o        = sel_m1 ? m1Write_i      : m0Write_i;
      devPhysicalAddr_o = sel_m1 ? m1Addr_i       : m0Addr_i;
      devDataSave_o     = sel_m1 ? m1DataSave_i   : m0DataSave_i;
      devByteSelect_o   = sel_m1 ? m1ByteSelect_i : m0ByteSelect_i;
    end
  end

  // The watchdog only fires on a cycle that would otherwise be another stall.
  assign done       = devEnable_o && !devBusy_i;
  assign abort      = WD_ON && devEnable_o && devBusy_i && (wd_count == WD_LAST);
  assign timeout_o  = abort;
  assign load_value = abort ? TIMEOUT_DATA : devDataLoad_i;

  assign m0Busy_o     = m0Enable_i && !((state == GNT0) && (done || abort));
  assign m1Busy_o     = m1Enable_i && !((state == GNT1) && (done || abort));
  assign m0DataLoad_o = (state == GNT0) ? load_value : 32'h0;
  assign m1DataLoad_o = (state == GNT1) ? load_value : 32'h0;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (m0Enable_i && m1Enable_i) state_next = last_grant ? GNT0 : GNT1;
        else if (m0Enable_i)          state_next = GNT0;
        else if (m1Enable_i)          state_next = GNT1;
        else                          state_next = IDLE;
      end
      GNT0, GNT1: begin
        if (!sel_enable || done || abort) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // lastGrant starts at 1 so master 0 wins the first tie after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      wd_count   <= '0;
      grant_o    <= 2'b00;
    end else begin
      state   <= state_next;
      grant_o <= {state_next == GNT1, state_next == GNT0};
      if (done || abort) last_grant <= sel_m1;
      if (devEnable_o && devBusy_i && !abort) wd_count <= wd_count + 1'b1;
      else                                    wd_count <= '0;
    end
  end

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Directed bench for dev_bus_arbiter: a vector table for single transactions plus
// hand sequences for ties, round-robin, watchdog abort and async reset.
module tb_dev_bus_arbiter;

  typedef struct packed {
    logic        m0En;
    logic        m0Wr;
    logic [31:0] m0Addr;
    logic [31:0] m0Data;
    logic [3:0]  m0Be;
    logic        m1En;
    logic        m1Wr;
    logic [31:0] m1Addr;
    logic [31:0] m1Data;
    logic [3:0]  m1Be;
    logic        devBusy;
    logic [31:0] devData;
  } in_t;

  typedef struct packed {
    logic        m0Busy;
    logic [31:0] m0Load;
    logic        m1Busy;
    logic [31:0] m1Load;
    logic        devEn;
    logic        devWr;
    logic [31:0] devAddr;
    logic [31:0] devSave;
    logic [3:0]  devBe;
    logic [1:0]  grant;
    logic        timeout;
  } out_t;

  typedef struct packed {
    in_t  stim;
    out_t exp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        m0Enable, m0Write, m0Busy;
  logic [31:0] m0Addr, m0DataSave, m0DataLoad;
  logic [3:0]  m0ByteSelect;
  logic        m1Enable, m1Write, m1Busy;
  logic [31:0] m1Addr, m1DataSave, m1DataLoad;
  logic [3:0]  m1ByteSelect;
  logic        devEnable, devWrite, devBusy;
  logic [31:0] devPhysicalAddr, devDataSave, devDataLoad;
  logic [3:0]  devByteSelect;
  logic [1:0]  grant;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  dev_bus_arbiter #(
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_DATA  (32'hDEADBEEF),
    .CNT_W         (13)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .m0Enable_i       (m0Enable),
    .m0Write_i        (m0Write),
    .m0Addr_i         (m0Addr),
    .m0DataSave_i     (m0DataSave),
    .m0ByteSelect_i   (m0ByteSelect),
    .m0Busy_o         (m0Busy),
    .m0DataLoad_o     (m0DataLoad),
    .m1Enable_i       (m1Enable),
    .m1Write_i        (m1Write),
    .m1Addr_i         (m1Addr),
    .m1DataSave_i     (m1DataSave),
    .m1ByteSelect_i   (m1ByteSelect),
    .m1Busy_o         (m1Busy),
    .m1DataLoad_o     (m1DataLoad),
    .devEnable_o      (devEnable),
    .devWrite_o       (devWrite),
    .devPhysicalAddr_o(devPhysicalAddr),
    .devDataSave_o    (devDataSave),
    .devByteSelect_o  (devByteSelect),
    .devBusy_i        (devBusy),
    .devDataLoad_i    (devDataLoad),
    .grant_o          (grant),
    .timeout_o        (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mkIn(logic e0, logic w0, logic [31:0] a0, logic [31:0] d0, logic [3:0] b0,
                               logic e1, logic w1, logic [31:0] a1, logic [31:0] d1, logic [3:0] b1,
                               logic busy, logic [31:0] data);
    in_t v;
    v = '{e0, w0, a0, d0, b0, e1, w1, a1, d1, b1, busy, data};
    return v;
  endfunction

  function automatic out_t mkOut(logic b0, logic [31:0] l0, logic b1, logic [31:0] l1,
                                 logic en, logic wr, logic [31:0] addr, logic [31:0] save,
                                 logic [3:0] be, logic [1:0] g, logic to);
    out_t v;
    v = '{b0, l0, b1, l1, en, wr, addr, save, be, g, to};
    return v;
  endfunction

  function automatic out_t sampleOut();
    out_t v;
    v = '{m0Busy, m0DataLoad, m1Busy, m1DataLoad, devEnable, devWrite,
          devPhysicalAddr, devDataSave, devByteSelect, grant, timeout};
    return v;
  endfunction

  task automatic applyStimulus(input in_t v);
    m0Enable = v.m0En; m0Write = v.m0Wr; m0Addr = v.m0Addr; m0DataSave = v.m0Data; m0ByteSelect = v.m0Be;
    m1Enable = v.m1En; m1Write = v.m1Wr; m1Addr = v.m1Addr; m1DataSave = v.m1Data; m1ByteSelect = v.m1Be;
    devBusy = v.devBusy; devDataLoad = v.devData;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] RD_A = 32'h9FD003F8;
  localparam logic [31:0] WR_A = 32'h80001000;
  localparam logic [31:0] WR_D = 32'h12345678;

  vec_t vecs[12];
  in_t  idleIn;
  out_t got;
  int   done0, done1;
  logic [1:0] expGrant;

  initial begin
    idleIn = mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // single read with 3 busy cycles, then a write from m1 with m0 queued behind it
    vecs[0]  = '{mkIn(1,0,RD_A,0,4'hF, 0,0,0,0,0, 1,0),            mkOut(1,0,0,0, 0,0,0,0,0, 2'b00,0)};
    vecs[1]  = '{mkIn(1,0,RD_A,0,4'hF, 0,0,0,0,0, 1,0),            mkOut(1,0,0,0, 1,0,RD_A,0,4'hF, 2'b01,0)};
    vecs[2]  = vecs[1];
    vecs[3]  = vecs[1];
    vecs[4]  = '{mkIn(1,0,RD_A,0,4'hF, 0,0,0,0,0, 0,32'h41),       mkOut(0,32'h41,0,0, 1,0,RD_A,0,4'hF, 2'b01,0)};
    vecs[5]  = '{idleIn,                                            mkOut(0,0,0,0, 0,0,0,0,0, 2'b00,0)};
    vecs[6]  = '{mkIn(0,0,0,0,0, 1,1,WR_A,WR_D,4'b0011, 1,0),      mkOut(0,0,1,0, 0,0,0,0,0, 2'b00,0)};
    vecs[7]  = '{mkIn(1,0,32'h100,0,4'hF, 1,1,WR_A,WR_D,4'b0011, 1,32'h55),
                 mkOut(1,0,1,32'h55, 1,1,WR_A,WR_D,4'b0011, 2'b10,0)};
    vecs[8]  = '{mkIn(1,0,32'h100,0,4'hF, 1,1,WR_A,WR_D,4'b0011, 0,32'hAA),
                 mkOut(1,0,0,32'hAA, 1,1,WR_A,WR_D,4'b0011, 2'b10,0)};
    vecs[9]  = '{mkIn(1,0,32'h100,0,4'hF, 0,0,0,0,0, 0,0),         mkOut(1,0,0,0, 0,0,0,0,0, 2'b00,0)};
    vecs[10] = '{mkIn(1,0,32'h100,0,4'hF, 0,0,0,0,0, 0,32'h77),    mkOut(0,32'h77,0,0, 1,0,32'h100,0,4'hF, 2'b01,0)};
    vecs[11] = '{idleIn,                                            mkOut(0,0,0,0, 0,0,0,0,0, 2'b00,0)};

    rst = 1'b1;
    applyStimulus(idleIn);
    cyc();
    cyc();
    checkOutput("reset_grant", 32'(grant), 32'h0);
    checkOutput("reset_timeout", 32'(timeout), 32'h0);
    checkOutput("reset_devEnable", 32'(devEnable), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].stim);
      #3;
      got = sampleOut();
      total++;
      if (got !== vecs[i].exp) begin
        bad++;
        $display("[TB] FAIL vec%0d: got %h expected %h", i, got, vecs[i].exp);
      end
      cyc();
    end

    // tie after reset: m0 first, idle gap, then m1
    rst = 1'b1;
    #2;
    rst = 1'b0;
    applyStimulus(mkIn(1,0,32'h10,0,4'hF, 1,0,32'h20,0,4'hF, 1,0));
    #1;
    checkOutput("tie_c0_grant", 32'(grant), 32'h0);
    checkOutput("tie_c0_m1Busy", 32'(m1Busy), 32'h1);
    cyc();
    #3;
    checkOutput("tie_c1_grant", 32'(grant), 32'h1);
    checkOutput("tie_c1_m1Busy", 32'(m1Busy), 32'h1);
    cyc();
    applyStimulus(mkIn(1,0,32'h10,0,4'hF, 1,0,32'h20,0,4'hF, 0,32'h5));
    #3;
    checkOutput("tie_c2_m0Busy", 32'(m0Busy), 32'h0);
    checkOutput("tie_c2_m1Busy", 32'(m1Busy), 32'h1);
    cyc();
    applyStimulus(mkIn(0,0,0,0,0, 1,0,32'h20,0,4'hF, 0,32'h6));
    #3;
    checkOutput("tie_c3_grant", 32'(grant), 32'h0);
    checkOutput("tie_c3_m1Busy", 32'(m1Busy), 32'h1);
    cyc();
    #3;
    checkOutput("tie_c4_grant", 32'(grant), 32'h2);
    checkOutput("tie_c4_m1Load", m1DataLoad, 32'h6);
    cyc();
    applyStimulus(idleIn);
    cyc();

    // both masters requesting continuously, one-cycle transactions
    done0 = 0;
    done1 = 0;
    applyStimulus(mkIn(1,0,32'h10,0,4'hF, 1,0,32'h20,0,4'hF, 0,32'h33));
    for (int t = 0; t < 16; t++) begin
      #3;
      if (t % 2 == 0)            expGrant = 2'b00;
      else if ((t / 2) % 2 == 0) expGrant = 2'b01;
      else                       expGrant = 2'b10;
      checkOutput($sformatf("rr_grant_t%0d", t), 32'(grant), 32'(expGrant));
      if (m0Enable && !m0Busy) done0++;
      if (m1Enable && !m1Busy) done1++;
      cyc();
    end
    checkOutput("rr_done_m0", 32'(done0), 32'd4);
    checkOutput("rr_done_m1", 32'(done1), 32'd4);
    applyStimulus(idleIn);
    cyc();

    // watchdog: m0 hangs, m1 queued behind it
    applyStimulus(mkIn(1,0,32'h200,0,4'hF, 0,0,0,0,0, 1,32'h1234));
    cyc();
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(mkIn(1,0,32'h200,0,4'hF, 1,0,32'h300,0,4'hF, 1,32'h1234));
      #3;
      if (k < 8) begin
        checkOutput($sformatf("wd_k%0d_m0Busy", k), 32'(m0Busy), 32'h1);
        checkOutput($sformatf("wd_k%0d_timeout", k), 32'(timeout), 32'h0);
      end else begin
        checkOutput("wd_abort_m0Busy", 32'(m0Busy), 32'h0);
        checkOutput("wd_abort_m0Load", m0DataLoad, 32'hDEADBEEF);
        checkOutput("wd_abort_timeout", 32'(timeout), 32'h1);
        checkOutput("wd_abort_m1Busy", 32'(m1Busy), 32'h1);
      end
      cyc();
    end
    applyStimulus(mkIn(0,0,0,0,0, 1,0,32'h300,0,4'hF, 1,0));
    #3;
    checkOutput("wd_after_timeout", 32'(timeout), 32'h0);
    checkOutput("wd_after_grant", 32'(grant), 32'h0);
    cyc();
    applyStimulus(mkIn(0,0,0,0,0, 1,0,32'h300,0,4'hF, 0,32'h99));
    #3;
    checkOutput("wd_m1_grant", 32'(grant), 32'h2);
    checkOutput("wd_m1_load", m1DataLoad, 32'h99);
    cyc();

    // a solo m0 transaction leaves lastGrant=0 so only reset can favour m0 next
    applyStimulus(mkIn(1,0,32'h400,0,4'hF, 0,0,0,0,0, 0,32'h7));
    cyc();
    #3;
    checkOutput("solo_m0_busy", 32'(m0Busy), 32'h0);
    cyc();
    applyStimulus(mkIn(0,0,0,0,0, 1,0,32'h500,0,4'hF, 1,0));
    cyc();
    #1;
    checkOutput("rst_pre_grant", 32'(grant), 32'h2);
    checkOutput("rst_pre_devEnable", 32'(devEnable), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_devEnable", 32'(devEnable), 32'h0);
    checkOutput("rst_mid_grant", 32'(grant), 32'h0);
    checkOutput("rst_mid_m1Busy", 32'(m1Busy), 32'h1);
    cyc();
    rst = 1'b0;
    applyStimulus(mkIn(1,0,32'h600,0,4'hF, 1,0,32'h500,0,4'hF, 1,0));
    #3;
    checkOutput("rst_post_idle", 32'(grant), 32'h0);
    cyc();
    #3;
    checkOutput("rst_post_tie_grant", 32'(grant), 32'h1);
    applyStimulus(idleIn);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
